// File: rtl/pipelined_color_mapper.sv
// pipelined_color_mapper: two-stage registered pixel colour mapper for the
// Space-Invaders display. Stage 1 classifies the pixel and addresses the
// synchronous sprite/ship ROMs; stage 2 picks the returned ROM bit and
// registers the final colour. A per-enemy tracker snapshots alive bits at
// frame_start and runs an explosion countdown for killed enemies.
// Optional build macro: ROW_PALETTE_EN (per-row alive enemy colours).
//
// Handshake: pix_valid marks DrawX/DrawY (and hud_pixel) as a real pixel in
// that cycle; there is no backpressure. out_valid is pix_valid delayed by
// exactly two clocks, and a cycle without pix_valid yields a black bubble.
module pipelined_color_mapper #(
  parameter int COLS        = 10,
  parameter int ROWS        = 6,
  parameter int CELL_LOG2   = 6,
  parameter int SCALE_LOG2  = 2,
  parameter int HUD_H       = 32,
  parameter int BOOM_FRAMES = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [9:0]           enemy_offset,
  input  logic [9:0]           enemy_top,
  input  logic [ROWS*COLS-1:0] enemy_status,
  input  logic                 anim_sel,
  input  logic [9:0]           player_offset,
  input  logic                 player_flash,
  input  logic                 missile_exists,
  input  logic                 pmissile_exists,
  input  logic [9:0]           missileX,
  input  logic [9:0]           missileY,
  input  logic [9:0]           pMissileX,
  input  logic [9:0]           pMissileY,
  input  logic                 hud_pixel,
  output logic [7:0]           sprite_addr,
  input  logic [7:0]           sprite_data,
  output logic [3:0]           ship_addr,
  input  logic [15:0]          ship_data,
  output logic                 out_valid,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [9:0]  SHIP_TOP  = 10'd448;
  localparam logic [23:0] WHITE     = 24'hFFFFFF;
  localparam logic [23:0] BOOM_RGB  = 24'hFF4000;
  localparam logic [23:0] SHIP_RGB  = 24'h00FFFF;

  typedef enum logic [2:0] {
    REG_BG,
    REG_HUD,
    REG_ALIVE,
    REG_BOOM,
    REG_MISSILE,
    REG_SHIP
  } region_e;

  // ---------------- explosion tracker state ----------------
  logic [N-1:0] snap_q, snap_d;
  logic [7:0]   boom_q [N];
  logic [7:0]   boom_d [N];
  logic         first_frame_q, first_frame_d;

  // Frame-boundary snapshot of alive bits and explosion countdown update
  always_comb begin
    snap_d        = snap_q;
    first_frame_d = first_frame_q;
    for (int i = 0; i < N; i++) boom_d[i] = boom_q[i];
    if (frame_start) begin
      snap_d        = enemy_status;
      first_frame_d = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (first_frame_q)        boom_d[i] = 8'd0;
        else if (enemy_status[i]) boom_d[i] = 8'd0;
        else if (snap_q[i])       boom_d[i] = 8'(BOOM_FRAMES);
        else if (boom_q[i] != 0)  boom_d[i] = boom_q[i] - 8'd1;
      end
    end
  end

  // Tracker registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      snap_q        <= '0;
      first_frame_q <= 1'b1;
      for (int i = 0; i < N; i++) boom_q[i] <= 8'd0;
    end else begin
      snap_q        <= snap_d;
      first_frame_q <= first_frame_d;
      for (int i = 0; i < N; i++) boom_q[i] <= boom_d[i];
    end
  end

  // ---------------- stage 1: classify and address ROMs ----------------
  logic [9:0]       nx, ny, cx, cy;
  logic [10:0]      sx_w, po_w;
  logic [IDX_W-1:0] idx;
  logic [2:0]       line, spx;
  logic [1:0]       row_clamp;
  logic [3:0]       ship_col;
  logic             in_hud, in_grid, enemy_alive, enemy_boom;
  logic             hit_emis, hit_pmis, in_ship;
  region_e          region_d, region_q;
  logic [3:0]       bit_d, bit_q;
  logic             hud_d, hud_q;
  logic             s1_valid_d, s1_valid_q;
`ifdef ROW_PALETTE_EN
  logic [1:0]       pal_d, pal_q;
`endif

  // Region classification, grid cell lookup and ROM address generation
  always_comb begin
    nx        = DrawX - enemy_offset;
    ny        = DrawY - enemy_top;
    cx        = nx >> CELL_LOG2;
    cy        = ny >> (CELL_LOG2 - 1);
    in_hud    = DrawY < 10'(HUD_H);
    in_grid   = (DrawX >= enemy_offset) && (DrawY >= enemy_top) &&
                (cx < 10'(COLS)) && (cy < 10'(ROWS)) && !nx[CELL_LOG2-1];
    idx       = in_grid ? IDX_W'(cy * 10'(COLS) + cx) : '0;
    enemy_alive = snap_q[idx];
    enemy_boom  = boom_q[idx] != 8'd0;
    line      = 3'(ny >> SCALE_LOG2);
    spx       = 3'(nx >> SCALE_LOG2);
    row_clamp = (cy >= 10'd2) ? 2'd2 : cy[1:0];
    // Explosion artwork lives at 48..55, shared by every enemy
    sprite_addr = enemy_alive ? {2'b00, row_clamp, anim_sel, line}
                              : {5'b00110, line};

    hit_emis  = missile_exists &&
                ((DrawX >> SCALE_LOG2) == (missileX >> SCALE_LOG2)) &&
                ((DrawY >> SCALE_LOG2) == (missileY >> SCALE_LOG2));
    hit_pmis  = pmissile_exists &&
                ((DrawX >> SCALE_LOG2) == (pMissileX >> SCALE_LOG2)) &&
                ((DrawY >> SCALE_LOG2) == (pMissileY >> SCALE_LOG2));

    // 11-bit compare so a ship near the right edge never wraps to X=0
    sx_w      = {1'b0, DrawX};
    po_w      = {1'b0, player_offset};
    in_ship   = (DrawY >= SHIP_TOP) && (sx_w >= po_w) &&
                (sx_w < po_w + 11'd64) && !player_flash;
    ship_col  = 4'((DrawX - player_offset) >> SCALE_LOG2);
    ship_addr = 4'((DrawY - SHIP_TOP) >> SCALE_LOG2);

    bit_d    = 4'd0;
    region_d = REG_BG;
    if (pix_valid) begin
      if (in_hud) begin
        region_d = REG_HUD;
      end else if (in_grid && (enemy_alive || enemy_boom)) begin
        region_d = enemy_alive ? REG_ALIVE : REG_BOOM;
        bit_d    = {1'b0, ~spx};
      end else if (hit_emis || hit_pmis) begin
        region_d = REG_MISSILE;
      end else if (in_ship) begin
        region_d = REG_SHIP;
        bit_d    = ~ship_col;
      end
    end
    hud_d      = hud_pixel;
    s1_valid_d = pix_valid;
`ifdef ROW_PALETTE_EN
    pal_d      = 2'(cy % 10'd3);
`endif
  end

  // Stage 1 pipeline registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      region_q   <= REG_BG;
      bit_q      <= 4'd0;
      hud_q      <= 1'b0;
`ifdef ROW_PALETTE_EN
      pal_q      <= 2'd0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      region_q   <= region_d;
      bit_q      <= bit_d;
      hud_q      <= hud_d;
`ifdef ROW_PALETTE_EN
      pal_q      <= pal_d;
`endif
    end
  end

  // ---------------- stage 2: ROM bit select and colour ----------------
  logic        pix_on;
  logic [23:0] alive_rgb, on_rgb, rgb_d, rgb_q;
  logic        out_valid_d, out_valid_q;

  // Pick the lit bit for the registered region and map it to a colour
  always_comb begin
`ifdef ROW_PALETTE_EN
    case (pal_q)
      2'd0:    alive_rgb = 24'hFF00FF;
      2'd1:    alive_rgb = 24'h00FF00;
      default: alive_rgb = 24'hFFFF00;
    endcase
`else
    alive_rgb = WHITE;
`endif
    pix_on = 1'b0;
    on_rgb = WHITE;
    case (region_q)
      REG_HUD:     pix_on = hud_q;
      REG_ALIVE: begin
        pix_on = sprite_data[bit_q[2:0]];
        on_rgb = alive_rgb;
      end
      REG_BOOM: begin
        pix_on = sprite_data[bit_q[2:0]];
        on_rgb = BOOM_RGB;
      end
      REG_MISSILE: pix_on = 1'b1;
      REG_SHIP: begin
        pix_on = ship_data[bit_q];
        on_rgb = SHIP_RGB;
      end
      default:     pix_on = 1'b0;
    endcase
    rgb_d       = (s1_valid_q && pix_on) ? on_rgb : 24'h000000;
    out_valid_d = s1_valid_q;
  end

  // Stage 2 output registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rgb_q       <= 24'h000000;
      out_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign VGA_R     = rgb_q[23:16];
  assign VGA_G     = rgb_q[15:8];
  assign VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_pipelined_color_mapper.sv
// Bench for pipelined_color_mapper: directed vector table, hand sequences
// for frame/explosion timing, then randomized traffic against a reference
// model built from the colour-mapping rules.
module tb_pipelined_color_mapper;

  localparam int COLS   = 10;
  localparam int ROWS   = 6;
  localparam int N      = ROWS * COLS;
  localparam int CELL_W = 64;
  localparam int CELL_H = 32;
  localparam int SCALE  = 4;
  localparam int HUD_H  = 32;
  localparam int BOOM   = 8;

  // ---------------- clock / reset / DUT signals ----------------
  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_start, pix_valid;
  logic [9:0]    DrawX, DrawY, enemy_offset, enemy_top;
  logic [N-1:0]  enemy_status;
  logic          anim_sel;
  logic [9:0]    player_offset;
  logic          player_flash, missile_exists, pmissile_exists;
  logic [9:0]    missileX, missileY, pMissileX, pMissileY;
  logic          hud_pixel;
  logic [7:0]    sprite_addr, sprite_data;
  logic [3:0]    ship_addr;
  logic [15:0]   ship_data;
  logic          out_valid;
  logic [7:0]    VGA_R, VGA_G, VGA_B;

  always #5 Clk = ~Clk;

  pipelined_color_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .enemy_offset(enemy_offset), .enemy_top(enemy_top),
    .enemy_status(enemy_status), .anim_sel(anim_sel),
    .player_offset(player_offset), .player_flash(player_flash),
    .missile_exists(missile_exists), .pmissile_exists(pmissile_exists),
    .missileX(missileX), .missileY(missileY),
    .pMissileX(pMissileX), .pMissileY(pMissileY),
    .hud_pixel(hud_pixel), .sprite_addr(sprite_addr),
    .sprite_data(sprite_data), .ship_addr(ship_addr),
    .ship_data(ship_data), .out_valid(out_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  // ---------------- ROM models (synchronous, 1-cycle read) ----------------
  logic rom_hash = 1'b0;

  function automatic logic [7:0] sprite_rom(input logic [7:0] a);
    return rom_hash ? 8'(a * 8'd37 + 8'd91) : 8'hFF;
  endfunction

  function automatic logic [15:0] ship_rom(input logic [3:0] a);
    return rom_hash ? 16'((16'(a) * 16'd2749) ^ 16'hA5C3) : 16'hFFFF;
  endfunction

  always @(posedge Clk) begin
    sprite_data <= sprite_rom(sprite_addr);
    ship_data   <= ship_rom(ship_addr);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] alive_rgb(input int r);
`ifdef ROW_PALETTE_EN
    case (r % 3)
      0:       return 24'hFF00FF;
      1:       return 24'h00FF00;
      default: return 24'hFFFF00;
    endcase
`else
    return 24'hFFFFFF;
`endif
  endfunction

  // ---------------- reference model ----------------
  bit m_snap[N];
  int m_boom[N];
  bit m_first;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_snap[i] = 1'b0;
      m_boom[i] = 0;
    end
    m_first = 1'b1;
  endtask

  task automatic model_frame();
    for (int i = 0; i < N; i++) begin
      if (m_first)              m_boom[i] = 0;
      else if (enemy_status[i]) m_boom[i] = 0;
      else if (m_snap[i])       m_boom[i] = BOOM;
      else if (m_boom[i] > 0)   m_boom[i] = m_boom[i] - 1;
      m_snap[i] = enemy_status[i];
    end
    m_first = 1'b0;
  endtask

  // Colour of the pixel currently on the inputs, using pre-frame state
  function automatic logic [23:0] model_rgb();
    int x, y, eo, et, nx, ny, c, r, i, ln, sx, sy, addr, po;
    logic [7:0]  sd;
    logic [15:0] shd;
    x = int'(DrawX); y = int'(DrawY);
    eo = int'(enemy_offset); et = int'(enemy_top);
    if (y < HUD_H) return hud_pixel ? 24'hFFFFFF : 24'h0;
    if (x >= eo && y >= et) begin
      nx = x - eo; ny = y - et;
      c = nx / CELL_W; r = ny / CELL_H;
      if (c < COLS && r < ROWS && (nx % CELL_W) < CELL_W / 2) begin
        i = r * COLS + c;
        if (m_snap[i] || m_boom[i] != 0) begin
          ln = (ny / SCALE) % 8;
          sx = (nx % CELL_W) / SCALE;
          if (m_snap[i]) addr = ln + 8 * int'(anim_sel) + 16 * ((r < 2) ? r : 2);
          else           addr = 48 + ln;
          sd = sprite_rom(8'(addr));
          if (!sd[7 - sx]) return 24'h0;
          return m_snap[i] ? alive_rgb(r) : 24'hFF4000;
        end
      end
    end
    if (missile_exists && x / SCALE == int'(missileX) / SCALE &&
        y / SCALE == int'(missileY) / SCALE) return 24'hFFFFFF;
    if (pmissile_exists && x / SCALE == int'(pMissileX) / SCALE &&
        y / SCALE == int'(pMissileY) / SCALE) return 24'hFFFFFF;
    po = int'(player_offset);
    if (y >= 448 && x >= po && x < po + 64 && !player_flash) begin
      sx = (x - po) / SCALE;
      sy = ((y - 448) / SCALE) % 16;
      shd = ship_rom(4'(sy));
      return shd[15 - sx] ? 24'h00FFFF : 24'h0;
    end
    return 24'h0;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a negedge; checks the colour two cycles later.
  task automatic pix(input string name, input int x, input int y, input logic hud,
                     input logic fs, input logic chk_addr, input logic [7:0] exp_addr,
                     input logic [23:0] exp_rgb);
    pix_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y); hud_pixel = hud;
    frame_start = fs;
    #1;
    if (chk_addr) check({name, " sprite_addr"}, 32'(sprite_addr), 32'(exp_addr));
    @(negedge Clk);
    pix_valid = 1'b0; hud_pixel = 1'b0; frame_start = 1'b0;
    @(negedge Clk);
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    int          x;
    int          y;
    logic        hud;
    logic        anim;
    logic        flash;
    logic        chk;
    logic [7:0]  addr;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input int x, input int y, input logic hud,
                     input logic anim, input logic flash, input logic chk,
                     input logic [7:0] addr, input logic [23:0] rgb);
    vec_t v;
    v.name = n; v.x = x; v.y = y; v.hud = hud; v.anim = anim; v.flash = flash;
    v.chk = chk; v.addr = addr; v.rgb = rgb;
    tbl.push_back(v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [24:0] e;
    logic [63:0] rnd;
    bit          do_rst;

    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b1;
    DrawX = 10'd4; DrawY = 10'd10; hud_pixel = 1'b1;
    enemy_offset = 10'd0; enemy_top = 10'd32; enemy_status = '0;
    anim_sel = 1'b0; player_offset = 10'd600; player_flash = 1'b0;
    missile_exists = 1'b0; pmissile_exists = 1'b0;
    missileX = 10'd200; missileY = 10'd300; pMissileX = 10'd200; pMissileY = 10'd300;

    // Reset held for 3 cycles with pix_valid high
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    check("release+1 out_valid", 32'(out_valid), 32'd0);
    @(negedge Clk);
    check("release+2 out_valid", 32'(out_valid), 32'd1);
    check("release+2 rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFFFFF);
    pix_valid = 1'b0; hud_pixel = 1'b0;

    // All enemies alive, first frame consumed
    enemy_status = '1;
    missile_exists = 1'b1; pmissile_exists = 1'b1;
    @(negedge Clk);
    frame_pulse();

    add("enemy0",      4,   33,  0, 0, 0, 1, 8'd0,  alive_rgb(0));
    add("gap_half",    36,  33,  0, 0, 0, 0, 8'd0,  24'h000000);
    add("anim1",       4,   33,  0, 1, 0, 1, 8'd8,  alive_rgb(0));
    add("line3",       4,   45,  0, 0, 0, 1, 8'd3,  alive_rgb(0));
    add("row1",        4,   65,  0, 0, 0, 1, 8'd16, alive_rgb(1));
    add("row2",        68,  97,  0, 0, 0, 1, 8'd32, alive_rgb(2));
    add("row3_clamp",  4,   133, 0, 0, 0, 1, 8'd33, alive_rgb(3));
    add("right_grid",  644, 33,  0, 0, 0, 0, 8'd0,  24'h000000);
    add("below_grid",  4,   225, 0, 0, 0, 0, 8'd0,  24'h000000);
    add("missile_tl",  200, 300, 0, 0, 0, 0, 8'd0,  24'hFFFFFF);
    add("missile_br",  203, 303, 0, 0, 0, 0, 8'd0,  24'hFFFFFF);
    add("missile_out", 204, 300, 0, 0, 0, 0, 8'd0,  24'h000000);
    add("ship_on",     639, 450, 0, 0, 0, 0, 8'd0,  24'h00FFFF);
    add("ship_flash",  639, 450, 0, 0, 1, 0, 8'd0,  24'h000000);
    add("ship_left",   599, 450, 0, 0, 0, 0, 8'd0,  24'h000000);
    add("hud_on",      4,   10,  1, 0, 0, 0, 8'd0,  24'hFFFFFF);
    add("hud_on_far",  639, 10,  1, 1, 1, 0, 8'd0,  24'hFFFFFF);
    add("hud_off",     4,   10,  0, 0, 0, 0, 8'd0,  24'h000000);

    foreach (tbl[i]) begin
      anim_sel = tbl[i].anim;
      player_flash = tbl[i].flash;
      pix(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].hud, 1'b0, tbl[i].chk,
          tbl[i].addr, tbl[i].rgb);
    end
    anim_sel = 1'b0; player_flash = 1'b0;

    // Each missile alone still lights the pixel
    missile_exists = 1'b0;
    pix("pmissile_only", 201, 301, 0, 0, 0, 8'd0, 24'hFFFFFF);
    missile_exists = 1'b1; pmissile_exists = 1'b0;
    pix("emissile_only", 201, 301, 0, 0, 0, 8'd0, 24'hFFFFFF);
    missile_exists = 1'b0;
    pix("no_missile", 201, 301, 0, 0, 0, 8'd0, 24'h000000);

    // Mid-frame kill has no effect until the next frame_start
    enemy_status[0] = 1'b0;
    pix("no_tear", 4, 33, 0, 0, 1, 8'd0, alive_rgb(0));
    frame_pulse();
    for (int f = 0; f < BOOM; f++) begin
      pix($sformatf("boom_frame%0d", f + 1), 4, 33, 0, 0, 1, 8'd48, 24'hFF4000);
      frame_pulse();
    end
    pix("boom_done", 4, 33, 0, 0, 0, 8'd0, 24'h000000);

    // frame_start in the pixel's own cycle: pixel sees the old snapshot
    enemy_status[0] = 1'b1;
    pix("fs_same_cycle", 4, 33, 0, 1, 0, 8'd0, 24'h000000);
    pix("revived", 4, 33, 0, 0, 1, 8'd0, alive_rgb(0));
    enemy_status[0] = 1'b0;
    frame_pulse();
    pix("rekill", 4, 33, 0, 0, 1, 8'd48, 24'hFF4000);

    // ---------------- randomized traffic vs reference model ----------------
    rom_hash = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clk);
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        check("rand out_valid", 32'(out_valid), 32'(e[24]));
        check("rand rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e[23:0]));
      end
      do_rst = (cyc == 0) || ($urandom_range(0, 599) == 0);
      Reset_n = !do_rst;
      pix_valid = $urandom_range(0, 9) < 8;
      frame_start = $urandom_range(0, 19) == 0;
      anim_sel = 1'($urandom_range(0, 1));
      hud_pixel = 1'($urandom_range(0, 1));
      player_flash = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 49) == 0) begin
        enemy_offset = 10'($urandom_range(0, 80));
        enemy_top = 10'($urandom_range(20, 90));
        player_offset = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 19) == 0) begin
        missileX = 10'($urandom_range(0, 639));
        missileY = 10'($urandom_range(0, 479));
        pMissileX = 10'($urandom_range(0, 639));
        pMissileY = 10'($urandom_range(0, 479));
        missile_exists = 1'($urandom_range(0, 1));
        pmissile_exists = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0)
        enemy_status[$urandom_range(0, N - 1)] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        rnd = {$urandom, $urandom};
        enemy_status = N'(rnd);
      end
      case ($urandom_range(0, 7))
        0: begin
          DrawX = 10'(int'(missileX) + int'($urandom_range(0, 8)) - 4);
          DrawY = 10'(int'(missileY) + int'($urandom_range(0, 8)) - 4);
        end
        1: begin
          DrawX = 10'(int'(pMissileX) + int'($urandom_range(0, 8)) - 4);
          DrawY = 10'(int'(pMissileY) + int'($urandom_range(0, 8)) - 4);
        end
        2: begin
          DrawX = 10'(int'(player_offset) + int'($urandom_range(0, 70)) - 3);
          DrawY = 10'($urandom_range(440, 479));
        end
        default: begin
          DrawX = 10'($urandom_range(0, 700));
          DrawY = 10'($urandom_range(0, 300));
        end
      endcase
      if (do_rst) begin
        exp_q.delete();
        exp_q.push_back(25'd0);
        exp_q.push_back(25'd0);
        model_reset();
      end else begin
        exp_q.push_back(pix_valid ? {1'b1, model_rgb()} : 25'd0);
        if (frame_start) model_frame();
      end
    end
    @(negedge Clk);
    pix_valid = 1'b0; frame_start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_color_mapper.md
Name: pipelined_color_mapper

Overview:
Registered, parametrised pixel colour mapper for the Space-Invaders display. Enemy grid size, cell size and HUD height are parameters, and the sprite and ship ROMs are synchronous. A per-enemy explosion tracker animates kills for a fixed number of frames. It sits between the VGA controller / game logic and the VGA DAC pins, with 2-cycle pixel latency.

Parameters:
COLS, 10, enemy grid columns (1..16)
ROWS, 6, enemy grid rows (1..8)
CELL_LOG2, 6, log2 of enemy cell pitch in pixels (cell = 64x32: width 2^CELL_LOG2, height 2^(CELL_LOG2-1))
SCALE_LOG2, 2, log2 of sprite pixel magnification
HUD_H, 32, height in lines of top HUD band
BOOM_FRAMES, 8, frames an explosion is shown (1..255)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  DrawX/DrawY valid this cycle
DrawX, DrawY  in  10 each  current pixel coordinates
enemy_offset, enemy_top  in  10 each  left X / top Y of enemy grid
enemy_status  in  ROWS*COLS  alive bits, index row*COLS+col
anim_sel  in  1  enemy animation frame select
player_offset  in  10  ship left X
player_flash  in  1  hide ship this frame
missile_exists, pmissile_exists  in  1 each  enemy / player missile present
missileX, missileY, pMissileX, pMissileY  in  10 each  missile positions
hud_pixel  in  1  combined lives/score text pixel, aligned with DrawX/DrawY input cycle
sprite_addr  out  8  sprite ROM address
sprite_data  in  8  sprite ROM row, valid 1 cycle after address
ship_addr  out  4  ship ROM address
ship_data  in  16  ship ROM row, valid 1 cycle after address
out_valid  out  1  pixel colour valid
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour

Behaviour:
- Reset (Reset_n=0 at Clk edge): VGA_R/G/B=0, out_valid=0, all boom counters=0, status snapshot=0, first_frame=1. Pipeline contents discarded.
- Pipeline stage 1 (cycle of pix_valid):
  - Classify the pixel into region HUD / enemy / enemy missile / player missile / ship / background.
  - Compute col=(DrawX-enemy_offset)>>CELL_LOG2 and row=(DrawY-enemy_top)>>(CELL_LOG2-1).
  - Drive sprite_addr and ship_addr.
  - Register region, bit index and hud_pixel.
- Pipeline stage 2: select the ROM bit and register the colour; out_valid = pix_valid delayed 2 cycles. When pix_valid=0 the stage-1 result is a bubble and the output is black.
- Enemy region:
  - DrawX>=enemy_offset, col<COLS, DrawY>=enemy_top, row<ROWS, lower-half of cell X (bit CELL_LOG2-1 of normalised X = 0), and the enemy is visible (snapshot bit=1 or boom counter!=0).
  - Line within sprite = normalised Y bits [SCALE_LOG2+2:SCALE_LOG2].
  - sprite_addr = line + 8*anim_sel + 16*min(row,2) for alive enemies; for exploding enemies, 48 + line.
- Missiles: match when DrawX>>SCALE_LOG2 == X>>SCALE_LOG2 and DrawY>>SCALE_LOG2 == Y>>SCALE_LOG2; colour white.
- Ship region: DrawY>=448, player_offset<=DrawX<player_offset+64 (11-bit compare, no wrap), player_flash=0; on-bit colour 00FFFF.
- Priority: HUD (DrawY<HUD_H) > enemy > enemy missile > player missile > ship > background 000000. HUD on-bit colour FFFFFF.
- Colours: alive enemy on-bit FFFFFF; exploding enemy on-bit FF4000; any off-bit 000000.
- Snapshot/explosion tracker, on each frame_start:
  - snapshot <= enemy_status.
  - If first_frame=1: no explosions; clear first_frame.
  - Otherwise, per enemy:
    - old=1, new=0: counter <= BOOM_FRAMES.
    - new=1: counter <= 0.
    - otherwise: counter decrements, saturating at 0.
  - Re-kill during a running explosion reloads BOOM_FRAMES.
- enemy_status changes mid-frame have no visible effect until the next frame_start (no tearing).
- frame_start coincident with pix_valid: the pixel uses the pre-update snapshot.
- Reset mid-frame: out_valid low for the 2 cycles after release.

Optional Feature:
ROW_PALETTE_EN.
- Defined: alive enemy on-bit colour is selected per row: row%3 = 0 → FF00FF, 1 → 00FF00, 2 → FFFF00.
- Undefined: all alive enemies are FFFFFF.
- Explosion colour is unaffected either way.

Test Plan:
- Reset_n=0 for 3 cycles with pix_valid=1 → VGA=000000, out_valid=0; after release, first out_valid exactly 2 cycles after first pix_valid.
- enemy_offset=0, enemy_top=32, all alive, anim_sel=0, sprite_data=FF, pixel (4,33) → FFFFFF 2 cycles later, sprite_addr=0 in the pix_valid cycle; pixel (36,33) → 000000 (gap half).
- Kill enemy 0 at frame_start #2 (first_frame already consumed) → pixel (4,33) shows FF4000 with sprite_addr=48 for the next 8 frames, background on the 9th.
- Clear status bit mid-frame with no frame_start → rendering unchanged until the next frame_start.
- Enemy missile and player missile both at (200,300), missile_exists=pmissile_exists=1 → FFFFFF at (200..203,300..303), 000000 at (204,300).
- player_offset=600, ship_data=FFFF, DrawX=639, DrawY=450 → 00FFFF; player_flash=1 → 000000; DrawY=10 with hud_pixel=1 → FFFFFF regardless of other inputs.
